// File: rtl/vout_pkg.sv
// -----------------------------------------------------------------------------
// vout_pkg
// Shared definitions for the video-out pixel reader:
//   - vout_state_e : reader FSM states (IDLE / ARMED / RUN)
//   - DEF_*        : default pixel width and raster timing (clocks / lines)
//   - cnt_w()      : width of a counter that must hold 0..total-1
// -----------------------------------------------------------------------------
package vout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } vout_state_e;

  localparam int DEF_WIDTH    = 8;

  localparam int DEF_H_ACTIVE = 8;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 2;
  localparam int DEF_H_BP     = 2;

  localparam int DEF_V_ACTIVE = 4;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BP     = 1;

  // A counter that wraps at 'total' needs at least one bit even for total=1.
  function automatic int cnt_w(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vout_timing_cnt.sv
// -----------------------------------------------------------------------------
// vout_timing_cnt
// Free-running raster counters and window decode. hcnt runs 0..H_TOTAL-1,
// vcnt advances on each hcnt wrap and runs 0..V_TOTAL-1. Both run from reset
// regardless of whether the reader is streaming.
// Ports:
//   i_clk        : pixel clock
//   i_rst_n      : asynchronous active-low reset (counters to 0)
//   o_active     : hcnt < H_ACTIVE and vcnt < V_ACTIVE
//   o_hs_win     : hcnt inside the horizontal sync window
//   o_vs_win     : vcnt inside the vertical sync window
//   o_frame_last : last clock of the frame (both counters at their maximum)
// -----------------------------------------------------------------------------
module vout_timing_cnt
  import vout_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_active,
  output logic o_hs_win,
  output logic o_vs_win,
  output logic o_frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_hcnt == H_LAST);
  assign w_v_last = (r_vcnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
    end else begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end

  assign o_active     = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
  assign o_hs_win     = (r_hcnt >= HS_FIRST) && (r_hcnt <= HS_LAST);
  assign o_vs_win     = (r_vcnt >= VS_FIRST) && (r_vcnt <= VS_LAST);
  assign o_frame_last = w_h_last && w_v_last;

endmodule

// File: rtl/vout_pixel_reader.sv
// -----------------------------------------------------------------------------
// vout_pixel_reader
// Read side of a video-out path: pops pixels from an async FIFO during the
// active region of a free-running raster and emits hsync/vsync/de/pixel with
// a fixed 2-clock latency from the counter decode.
// Streaming starts only on a frame boundary (IDLE -> ARMED -> RUN) and stops
// only on a frame boundary, so a frame is never emitted partially.
// Ports:
//   clk_r      : pixel clock (only clock)
//   rst_n_r    : asynchronous active-low reset
//   enable     : start/stop request
//   clr_err    : clears the sticky underflow flag
//   empty      : FIFO empty
//   data_r     : FIFO read data, valid the cycle after a pop
//   en_r       : FIFO pop request (combinational, never asserted when empty)
//   hsync      : horizontal sync, SYNC_ACT polarity
//   vsync      : vertical sync, SYNC_ACT polarity
//   de         : data enable (active region, in every state)
//   pixel      : popped data, UNDERFLOW_PIXEL on a miss, 0 otherwise
//   underflow  : sticky flag, set after a miss reaches the output stage
//   running    : high while in RUN
// -----------------------------------------------------------------------------
module vout_pixel_reader
  import vout_pkg::*;
#(
  parameter int               WIDTH           = DEF_WIDTH,
  parameter int               H_ACTIVE        = DEF_H_ACTIVE,
  parameter int               H_FP            = DEF_H_FP,
  parameter int               H_SYNC          = DEF_H_SYNC,
  parameter int               H_BP            = DEF_H_BP,
  parameter int               V_ACTIVE        = DEF_V_ACTIVE,
  parameter int               V_FP            = DEF_V_FP,
  parameter int               V_SYNC          = DEF_V_SYNC,
  parameter int               V_BP            = DEF_V_BP,
  parameter logic             SYNC_ACT        = 1'b1,
  parameter logic [WIDTH-1:0] UNDERFLOW_PIXEL = '1
) (
  input  logic             clk_r,
  input  logic             rst_n_r,
  input  logic             enable,
  input  logic             clr_err,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_r,
  output logic             en_r,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [WIDTH-1:0] pixel,
  output logic             underflow,
  output logic             running
);

  // Pixel select for the output stage: a pop wins over a miss (they are
  // mutually exclusive by construction), anything else drives black.
  function automatic logic [WIDTH-1:0] sel_pixel(input logic             pop,
                                                 input logic             miss,
                                                 input logic [WIDTH-1:0] d);
    if (pop)       return d;
    else if (miss) return UNDERFLOW_PIXEL;
    else           return '0;
  endfunction

  vout_state_e      r_state;
  vout_state_e      w_state_nxt;

  logic             w_active;
  logic             w_hs_win;
  logic             w_vs_win;
  logic             w_frame_last;
  logic             w_run;
  logic             w_pop;
  logic             w_miss;

  logic             r_hs_p1;
  logic             r_vs_p1;
  logic             r_de_p1;
  logic             r_pop_p1;
  logic             r_miss_p1;

  logic             r_hsync_p2;
  logic             r_vsync_p2;
  logic             r_de_p2;
  logic [WIDTH-1:0] r_pixel_p2;
  logic             r_miss_p2;
  logic             r_underflow;

  vout_timing_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk        (clk_r),
    .i_rst_n      (rst_n_r),
    .o_active     (w_active),
    .o_hs_win     (w_hs_win),
    .o_vs_win     (w_vs_win),
    .o_frame_last (w_frame_last)
  );

  // ---------------------------------------------------------------------------
  // Reader FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_r or negedge rst_n_r) begin
    if (!rst_n_r) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ARMED waits for the last clock of a frame so RUN always begins at
  // hcnt=0/vcnt=0; RUN keeps going until the frame ends even if enable drops.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && !empty) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!enable)           w_state_nxt = ST_IDLE;
        else if (w_frame_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_frame_last && !enable) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_run   = (r_state == ST_RUN);
  assign running = w_run;

  // Pop and miss are decoded in the same cycle as the counters; the FIFO
  // answers with data_r one clock later, lining up with stage 1.
  assign w_pop  = w_run && w_active && !empty;
  assign w_miss = w_run && w_active &&  empty;
  assign en_r   = w_pop;

  // ---------------------------------------------------------------------------
  // Stage 1: registered decode, pop/miss tags (data_r valid here)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_r or negedge rst_n_r) begin
    if (!rst_n_r) begin
      r_hs_p1   <= 1'b0;
      r_vs_p1   <= 1'b0;
      r_de_p1   <= 1'b0;
      r_pop_p1  <= 1'b0;
      r_miss_p1 <= 1'b0;
    end else begin
      r_hs_p1   <= w_hs_win;
      r_vs_p1   <= w_vs_win;
      r_de_p1   <= w_active;
      r_pop_p1  <= w_pop;
      r_miss_p1 <= w_miss;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_r or negedge rst_n_r) begin
    if (!rst_n_r) begin
      r_hsync_p2 <= ~SYNC_ACT;
      r_vsync_p2 <= ~SYNC_ACT;
      r_de_p2    <= 1'b0;
      r_pixel_p2 <= '0;
      r_miss_p2  <= 1'b0;
    end else begin
      r_hsync_p2 <= r_hs_p1 ? SYNC_ACT : ~SYNC_ACT;
      r_vsync_p2 <= r_vs_p1 ? SYNC_ACT : ~SYNC_ACT;
      r_de_p2    <= r_de_p1;
      r_pixel_p2 <= sel_pixel(r_pop_p1, r_miss_p1, data_r);
      r_miss_p2  <= r_miss_p1;
    end
  end

  // Sticky error: a miss that has reached the output sets it one clock later;
  // the set term takes priority so a clear can never hide a fresh miss.
  always_ff @(posedge clk_r or negedge rst_n_r) begin
    if (!rst_n_r)       r_underflow <= 1'b0;
    else if (r_miss_p2) r_underflow <= 1'b1;
    else if (clr_err)   r_underflow <= 1'b0;
  end

  assign hsync     = r_hsync_p2;
  assign vsync     = r_vsync_p2;
  assign de        = r_de_p2;
  assign pixel     = r_pixel_p2;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_vout_pixel_reader.sv
module tb_vout_pixel_reader;

  localparam int W     = 8;
  localparam int HA    = 8;
  localparam int HF    = 2;
  localparam int HS    = 2;
  localparam int HT    = 14;
  localparam int VA    = 4;
  localparam int VF    = 1;
  localparam int VS    = 1;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;

  logic         clk     = 1'b0;
  logic         rst_n_r = 1'b1;
  logic         enable  = 1'b0;
  logic         clr_err = 1'b0;
  logic         empty   = 1'b1;
  logic [W-1:0] data_r  = '0;
  logic         en_r;
  logic         hsync;
  logic         vsync;
  logic         de;
  logic [W-1:0] pixel;
  logic         underflow;
  logic         running;

  always #5 clk = ~clk;

  vout_pixel_reader dut (
    .clk_r     (clk),
    .rst_n_r   (rst_n_r),
    .enable    (enable),
    .clr_err   (clr_err),
    .empty     (empty),
    .data_r    (data_r),
    .en_r      (en_r),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .pixel     (pixel),
    .underflow (underflow),
    .running   (running)
  );

  typedef struct packed {
    logic         hs;
    logic         vs;
    logic         de;
    logic [W-1:0] pix;
  } out_t;

  typedef struct {
    int preload;
    bit en;
    int cycles;
    int exp_pops;
    int exp_ff;
    int exp_de;
    int exp_hs;
    int exp_vs;
    bit exp_uf;
  } vec_t;

  out_t         sb[$];
  logic [W-1:0] fifo_q[$];

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n;
  int   mh, mv, ms;
  logic mu, m1, m2;
  int   pops, ff_cnt, de_cnt, hs_cnt, vs_cnt, win;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, n, got, exp);
    end
  endtask

  // One clock: check this cycle at negedge, advance the reference at posedge,
  // then the FIFO model answers a pop 1 time unit after the edge.
  task automatic step();
    logic act, last, e_run, e_en, e_miss, pop;
    out_t e, g;
    @(negedge clk);
    act    = (mh < HA) && (mv < VA);
    last   = (mh == HT - 1) && (mv == VT - 1);
    e_run  = (ms == 2);
    e_en   = e_run && act && !empty;
    e_miss = e_run && act && empty;
    chk("en_r", 32'(en_r), 32'(e_en));
    chk("running", 32'(running), 32'(e_run));
    chk("underflow", 32'(underflow), 32'(mu));
    chk("pop_while_empty", 32'(en_r & empty), 32'd0);
    g = sb.pop_front();
    chk("de", 32'(de), 32'(g.de));
    chk("hsync", 32'(hsync), 32'(g.hs));
    chk("vsync", 32'(vsync), 32'(g.vs));
    chk("pixel", 32'(pixel), 32'(g.pix));
    e.de  = act;
    e.hs  = (mh >= HA + HF) && (mh < HA + HF + HS);
    e.vs  = (mv >= VA + VF) && (mv < VA + VF + VS);
    e.pix = e_en ? fifo_q[0] : (e_miss ? 8'hFF : 8'h00);
    sb.push_back(e);
    if (en_r === 1'b1 && n < win) pops++;
    if (de === 1'b1)        de_cnt++;
    if (hsync === 1'b1)     hs_cnt++;
    if (vsync === 1'b1)     vs_cnt++;
    if (pixel === 8'hFF)    ff_cnt++;
    pop = en_r;
    @(posedge clk);
    mu = m2 ? 1'b1 : (clr_err ? 1'b0 : mu);
    m2 = m1;
    m1 = e_miss;
    case (ms)
      0: if (enable && !empty) ms = 1;
      1: if (!enable) ms = 0; else if (last) ms = 2;
      2: if (last && !enable) ms = 0;
      default: ms = 0;
    endcase
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    #1;
    if (pop === 1'b1 && fifo_q.size() > 0) data_r = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic do_reset();
    rst_n_r = 1'b0;
    #1;
    chk("rst_en_r", 32'(en_r), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd0);
    chk("rst_vsync", 32'(vsync), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    enable  = 1'b0;
    clr_err = 1'b0;
    fifo_q.delete();
    empty   = 1'b1;
    data_r  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_r = 1'b1;
    mh = 0; mv = 0; ms = 0; mu = 1'b0; m1 = 1'b0; m2 = 1'b0; n = 0;
    sb.delete();
    sb.push_back('0);
    sb.push_back('0);
    pops = 0; ff_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    win = 1 << 30;
  endtask

  task automatic preload(input int cnt);
    for (int k = 0; k < cnt; k++) fifo_q.push_back(W'(k));
    empty = (fifo_q.size() == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", n);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[4];
    tbl[0] = '{preload: 0,  en: 1'b0, cycles: 2*FRAME, exp_pops: 0,  exp_ff: 0,  exp_de: 64, exp_hs: 28, exp_vs: 28, exp_uf: 1'b0};
    tbl[1] = '{preload: 32, en: 1'b1, cycles: 2*FRAME, exp_pops: 32, exp_ff: 0,  exp_de: 64, exp_hs: 28, exp_vs: 28, exp_uf: 1'b0};
    tbl[2] = '{preload: 5,  en: 1'b1, cycles: 2*FRAME, exp_pops: 5,  exp_ff: 27, exp_de: 64, exp_hs: 28, exp_vs: 28, exp_uf: 1'b1};
    tbl[3] = '{preload: 0,  en: 1'b1, cycles: 2*FRAME, exp_pops: 0,  exp_ff: 0,  exp_de: 64, exp_hs: 28, exp_vs: 28, exp_uf: 1'b0};

    #2;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      preload(tbl[i].preload);
      enable = tbl[i].en;
      win    = tbl[i].cycles;
      run_to(tbl[i].cycles + 2);
      chk($sformatf("row%0d_pops", i), 32'(pops), 32'(tbl[i].exp_pops));
      chk($sformatf("row%0d_ff_pixels", i), 32'(ff_cnt), 32'(tbl[i].exp_ff));
      chk($sformatf("row%0d_de_clocks", i), 32'(de_cnt), 32'(tbl[i].exp_de));
      chk($sformatf("row%0d_hsync_clocks", i), 32'(hs_cnt), 32'(tbl[i].exp_hs));
      chk($sformatf("row%0d_vsync_clocks", i), 32'(vs_cnt), 32'(tbl[i].exp_vs));
      chk($sformatf("row%0d_underflow", i), 32'(underflow), 32'(tbl[i].exp_uf));
    end

    // clr_err during a miss streak keeps the flag; in blanking it clears.
    do_reset();
    preload(5);
    enable = 1'b1;
    run_to(FRAME + 2*HT + 2);
    chk("clr_pre_flag", 32'(underflow), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_with_miss_holds", 32'(underflow), 32'd1);
    run_to(FRAME + 5*HT);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_no_miss_clears", 32'(underflow), 32'd0);

    // enable dropped on line 1 of a running frame: the frame completes.
    do_reset();
    preload(64);
    enable = 1'b1;
    run_to(FRAME + HT + 3);
    enable = 1'b0;
    run_to(2*FRAME);
    chk("stop_running_low", 32'(running), 32'd0);
    chk("stop_frame_pops", 32'(pops), 32'd32);
    run_to(3*FRAME);
    chk("stop_no_more_pops", 32'(pops), 32'd32);

    // reset asserted mid-frame at line 2, hcnt 3 while streaming.
    do_reset();
    preload(64);
    enable = 1'b1;
    run_to(FRAME + 2*HT + 3);
    chk("midrst_popping", 32'(en_r), 32'd1);
    do_reset();
    preload(64);
    enable = 1'b1;
    run_to(FRAME);
    chk("midrst_no_early_pop", 32'(pops), 32'd0);
    step();
    chk("midrst_first_pop_at_boundary", 32'(pops), 32'd1);
    run_to(FRAME + 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
